sram_port_arbiter: RTL

//  Shares one SRAM-like request port between the core's instruction and data requesters.

---
 rtl/sram_port_arbiter_if.sv | 27 ++
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   One SRAM-like request/response port: request phase (req/wr/uncached/size/
//   addr/wdata, accepted by addr_ok) and in-order response phase
//   (data_ok/rdata).
//   master : the side that issues requests (drives req..wdata)
//   slave  : the side that accepts requests (drives addr_ok, data_ok, rdata)
interface sram_port_arbiter_if;
  logic        req;
  logic        wr;
  logic        uncached;
  logic [1:0]  size;      // bytes-1: 0=1B, 1=2B, 2=4B
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, uncached, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, uncached, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one SRAM-like downstream port (m) between the core's instruction
//   (inst) and data (data) requesters. Request phases are arbitrated
//   combinationally; every accepted request records its source ID in a small
//   FIFO so the in-order downstream responses can be routed back to the
//   requester that issued them.
// Ports
//   clk, rst     clock, synchronous active-high reset
//   inst         slave port facing the instruction requester
//   data         slave port facing the data requester
//   m            master port facing the downstream (cpu_axi_interface)
//   outstanding  accepted-but-unanswered request count (0..MAX_OUTSTANDING)
//   rsp_err      sticky: a response arrived while nothing was in flight
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,  // power of 2, >= 2
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  sram_port_arbiter_if.slave               inst,
  sram_port_arbiter_if.slave               data,
  sram_port_arbiter_if.master              m,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             rsp_err
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  // State
  logic          lock;
  src_e          lock_src;
  logic [SW-1:0] starve_cnt;
  src_e          fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Combinational decisions
  src_e sel;
  logic sel_req;
  logic starved;
  logic full;
  logic empty;
  logic m_req_int;
  logic accept;
  logic pop;
  src_e head;

  assign starved = (starve_cnt >= SW'(STARVE_LIMIT));
  // Full blocks new requests even if a response pops this same cycle, so
  // there is no combinational path from m.data_ok to m.req.
  assign full    = (count == CW'(MAX_OUTSTANDING));
  assign empty   = (count == '0);
  assign head    = fifo_mem[rd_ptr];

  // Grant: while locked the previously granted source keeps the bus so the
  // m fields stay stable until accepted; otherwise data has priority unless
  // inst has waited STARVE_LIMIT cycles.
  // NOTE: every signal assigned in this always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = SRC_INST;
    if (lock) begin
      sel = lock_src;
    end else if (data.req && !(inst.req && starved)) begin
      sel = SRC_DATA;
    end
  end

  assign sel_req   = (sel == SRC_DATA) ? data.req : inst.req;
  assign m_req_int = !rst && !full && sel_req;
  assign accept    = m_req_int && m.addr_ok;
  assign pop       = !rst && m.data_ok && !empty;

  // Downstream request mux (zero-latency)
  assign m.req      = m_req_int;
  assign m.wr       = (sel == SRC_DATA) ? data.wr       : inst.wr;
  assign m.uncached = (sel == SRC_DATA) ? data.uncached : inst.uncached;
  assign m.size     = (sel == SRC_DATA) ? data.size     : inst.size;
  assign m.addr     = (sel == SRC_DATA) ? data.addr     : inst.addr;
  assign m.wdata    = (sel == SRC_DATA) ? data.wdata    : inst.wdata;

  // Upstream handshakes
  assign inst.addr_ok = accept && (sel == SRC_INST);
  assign data.addr_ok = accept && (sel == SRC_DATA);
  assign inst.data_ok = pop && (head == SRC_INST);
  assign data.data_ok = pop && (head == SRC_DATA);
  assign inst.rdata   = m.rdata;
  assign data.rdata   = m.rdata;

  assign outstanding = count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock       <= 1'b0;
      lock_src   <= SRC_INST;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // Lock holds the granted source across downstream back-pressure; it
      // also clears when the requester withdraws (m.req drops).
      lock     <= m_req_int && !m.addr_ok;
      lock_src <= sel;

      if (!inst.req || (accept && sel == SRC_INST)) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (m.data_ok && empty) rsp_err <= 1'b1;
    end
  end

  // NOTE: the ID storage is not reset; the pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= sel;
  end

endmodule
